imem_responder: RTL and testbench
=================================

# imem_responder

Multi-cycle instruction-memory responder: the memory-side end of the fetch/instruction-memory interface. Accepts one read or write request at a time from the fetch stage (or a program loader), models a fixed access latency, returns data with a one-cycle `done` pulse, and asserts `stall` while busy so the requester holds its PC. Unaligned or conflicting requests are rejected with a one-cycle `err` pulse, which the fetch stage latches into its sticky memory-error flag.

## Interface
- `LATENCY`, 3: cycles from request acceptance to completion; legal range 1..15.
- `AW`, 8: word-address bits; storage is 2^AW 16-bit words.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_rd`  in  1  read request; sampled only in IDLE.
- `req_wr`  in  1  write request; sampled only in IDLE.
- `addr`  in  16  byte address; word index = `addr[AW:1]`; `addr[15:AW+1]` ignored (wrap).
- `data_in`  in  16  write data; sampled with the request.
- `data_out`  out  16  read data; registered; holds until the next read completes.
- `done`  out  1  one-cycle pulse on completion of an accepted read or write.
- `stall`  out  1  high while state is BUSY; requester must not expect acceptance.
- `err`  out  1  one-cycle pulse for a rejected request.

## Operation
- States: IDLE, BUSY. Registers: `state`, `cnt[3:0]`, `op_wr`, `word_idx[AW-1:0]`, `wdata[15:0]`, `data_out`, `done`, `err`, storage array.
- IDLE, edge with `req_rd|req_wr`:
  - `addr[0]==1`, or `req_rd&req_wr` -> `err<=1` next cycle, no access, stay IDLE.
  - otherwise latch `op_wr<=req_wr`, `word_idx<=addr[AW:1]`, `wdata<=data_in`, `cnt<=LATENCY-1`, go BUSY.
- BUSY, each edge:
  - `cnt!=0` -> `cnt<=cnt-1`.
  - `cnt==0` -> complete: read loads `data_out<=mem[word_idx]`; write stores `mem[word_idx]<=wdata`; `done<=1`; go IDLE.
- `req_rd`/`req_wr`/`addr`/`data_in` ignored while BUSY (no queueing); requester re-presents after `done`.
- `done` and `err` are self-clearing: 0 on any edge that does not set them.
- `stall = (state==BUSY)`, registered-state decode, no combinational path from request inputs.
- Storage is not cleared by reset; contents are undefined until written.

## Timing
- Request accepted at edge t -> `done` (and valid read `data_out`) high in the cycle after edge t+LATENCY; `stall` high cycles after edges t..t+LATENCY-1.
- LATENCY=1: `stall` high exactly one cycle, `done` the next.
- Back-to-back: state is IDLE while `done` is high, so a request presented in the `done` cycle is accepted at that edge; sustained throughput one access per LATENCY+1 cycles.
- Rejected request: `err` high the cycle after the sampling edge; `stall` stays 0; a new request is accepted in the `err` cycle.
- Reset values: `state`=IDLE, `cnt`=0, `data_out`=0, `done`=0, `err`=0, `stall`=0.
- Reset mid-BUSY: access aborted; a pending write is not performed; no `done` pulse after reset release.
- Address wrap: with AW=8, `addr`=16'h0202 and 16'h0002 map to word 1.

## Test plan
- Reset, write 16'hBEEF to addr 16'h0010 (LATENCY=3), then read 16'h0010 -> `stall` high 3 cycles each, `done` pulse on 4th cycle after acceptance, `data_out`=16'hBEEF.
- Read at addr 16'h0011 -> `err` single-cycle pulse, `stall`=0, `done`=0, `data_out` unchanged; same for `req_rd=req_wr=1` at 16'h0010.
- Read 16'h0010 held continuously -> successive `done` pulses every 4 cycles, each `data_out`=16'hBEEF.
- During BUSY of a read of 16'h0010, pulse `req_wr` to 16'h0020 with 16'h1234 -> ignored; subsequent read of 16'h0020 returns prior contents, not 16'h1234.
- Write 16'h5A5A to 16'h0030, assert `rst` with `cnt`=1 -> all outputs 0 asynchronously, no `done`; after release, write 16'h0000 then read 16'h0030 -> 16'h0000 (earlier write provably aborted or overwritten; check via read before the second write returns the pre-reset value).
- Write 16'hCAFE to 16'h0202 (AW=8), read 16'h0002 -> `data_out`=16'hCAFE; repeat with LATENCY=1 -> `done` 2 cycles after acceptance edge sequence (stall 1 cycle).

Source files
------------

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - multi-cycle instruction-memory responder
//
// Purpose: memory-side end of the fetch/instruction-memory interface. It
// accepts one read or write at a time, models a fixed access latency, then
// returns read data with a one-cycle done pulse. Misaligned or conflicting
// requests get a one-cycle err pulse instead.
//
// Parameters:
//   LATENCY  cycles from acceptance to completion (1..15)
//   AW       word-address bits; storage is 2^AW 16-bit words
//
// Ports:
//   i_clk       system clock, rising edge
//   i_rst       asynchronous active-high reset
//   i_req_rd    read request, sampled only while idle
//   i_req_wr    write request, sampled only while idle
//   i_addr      byte address; word index = i_addr[AW:1], upper bits wrap
//   i_data_in   write data, sampled with the request
//   o_data_out  registered read data, holds until the next read completes
//   o_done      one-cycle pulse when an accepted access completes
//   o_stall     high while an access is in flight
//   o_err       one-cycle pulse for a rejected request
module imem_responder #(
  parameter int LATENCY = 3,
  parameter int AW      = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_rd,
  input  logic        i_req_wr,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_data_in,
  output logic [15:0] o_data_out,
  output logic        o_done,
  output logic        o_stall,
  output logic        o_err
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  // Counter is loaded with LATENCY-1 so that completion lands on the
  // LATENCY-th edge after acceptance.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t          r_state;
  state_t          w_state_next;
  logic [3:0]      r_cnt;
  logic            r_op_wr;
  logic [AW-1:0]   r_word_idx;
  logic [15:0]     r_wdata;
  logic [15:0]     r_mem [2**AW];

  logic            w_req;
  logic            w_accept;
  logic            w_reject;
  logic            w_complete;
  logic            w_unused_addr;

  // High address bits intentionally alias onto the same words.
  assign w_unused_addr = ^i_addr[15:AW+1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_req        = i_req_rd | i_req_wr;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (i_addr[0] || (i_req_rd && i_req_wr)) begin
            w_reject = 1'b1;
          end else begin
            w_accept     = 1'b1;
            w_state_next = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (r_cnt == 4'd0) begin
          w_complete   = 1'b1;
          w_state_next = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt      <= 4'd0;
      r_op_wr    <= 1'b0;
      r_word_idx <= '0;
      r_wdata    <= 16'd0;
      o_data_out <= 16'd0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_done <= w_complete;
      o_err  <= w_reject;
      if (w_accept) begin
        r_op_wr    <= i_req_wr;
        r_word_idx <= i_addr[AW:1];
        r_wdata    <= i_data_in;
        r_cnt      <= CNT_LOAD;
      end else if ((r_state == S_BUSY) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_complete && !r_op_wr) begin
        o_data_out <= r_mem[r_word_idx];
      end
    end
  end

  // Storage has no reset. A reset during BUSY forces IDLE immediately, so
  // w_complete cannot fire and a pending write is dropped.
  always_ff @(posedge i_clk) begin
    if (w_complete && r_op_wr) begin
      r_mem[r_word_idx] <= r_wdata;
    end
  end

  assign o_stall = (r_state == S_BUSY);

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - self-checking bench for imem_responder
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd0 = 1'b0, wr0 = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
  logic [15:0] a0 = 16'd0, d0 = 16'd0, a1 = 16'd0, d1 = 16'd0;
  logic [15:0] q0, q1;
  logic        done0, stall0, err0, done1, stall1, err1;

  int n_tests = 0;
  int n_fail  = 0;

  imem_responder #(.LATENCY(3), .AW(8)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_req_rd(rd0), .i_req_wr(wr0), .i_addr(a0),
    .i_data_in(d0), .o_data_out(q0), .o_done(done0), .o_stall(stall0), .o_err(err0));

  imem_responder #(.LATENCY(1), .AW(8)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_req_rd(rd1), .i_req_wr(wr1), .i_addr(a1),
    .i_data_in(d1), .o_data_out(q1), .o_done(done1), .o_stall(stall1), .o_err(err1));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request, then follows it: lat = edges from acceptance to the
  // cycle where done is seen (-1 if never), stalls = cycles with stall high.
  task automatic do_op(input int sel, input logic rd, input logic wr,
                       input logic [15:0] a, input logic [15:0] d,
                       output int lat, output int stalls, output logic saw_err);
    if (sel == 0) begin rd0 = rd; wr0 = wr; a0 = a; d0 = d; end
    else          begin rd1 = rd; wr1 = wr; a1 = a; d1 = d; end
    tick();
    rd0 = 1'b0; wr0 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
    lat = -1;
    stalls = 0;
    saw_err = (sel == 0) ? err0 : err1;
    if (saw_err) return;
    for (int k = 0; k < 40; k++) begin
      if ((sel == 0) ? stall0 : stall1) stalls++;
      if ((sel == 0) ? done0 : done1) begin lat = k; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_tests++; if (q0 !== 16'd0) begin n_fail++; $display("FAIL reset_data got %h want 0000", q0); end
    n_tests++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done0); end
    n_tests++; if (stall0 !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall0); end
    n_tests++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err0); end
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    int lat, st;
    logic e;
    do_op(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, lat, st, e);
    n_tests++; if (lat !== 3 || st !== 3) begin n_fail++; $display("FAIL wr_timing got lat=%0d stall=%0d want 3/3", lat, st); end
    do_op(0, 1'b1, 1'b0, 16'h0010, 16'h0000, lat, st, e);
    n_tests++; if (lat !== 3 || st !== 3) begin n_fail++; $display("FAIL rd_timing got lat=%0d stall=%0d want 3/3", lat, st); end
    n_tests++; if (q0 !== 16'hBEEF) begin n_fail++; $display("FAIL rd_data got %h want beef", q0); end
    tick();
    n_tests++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width got %b want 0", done0); end
  endtask

  task automatic test_err();
    int lat, st;
    logic e;
    logic [15:0] prev;
    prev = q0;
    do_op(0, 1'b1, 1'b0, 16'h0011, 16'h0000, lat, st, e);
    n_tests++; if (e !== 1'b1 || stall0 !== 1'b0 || done0 !== 1'b0) begin n_fail++; $display("FAIL err_odd got err=%b stall=%b done=%b want 1/0/0", e, stall0, done0); end
    n_tests++; if (q0 !== prev) begin n_fail++; $display("FAIL err_data got %h want %h", q0, prev); end
    tick();
    n_tests++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL err_pulse_width got %b want 0", err0); end
    do_op(0, 1'b1, 1'b1, 16'h0010, 16'h0000, lat, st, e);
    n_tests++; if (e !== 1'b1 || stall0 !== 1'b0 || done0 !== 1'b0) begin n_fail++; $display("FAIL err_both got err=%b stall=%b done=%b want 1/0/0", e, stall0, done0); end
    // A fresh request presented during the err cycle must be accepted.
    do_op(0, 1'b1, 1'b0, 16'h0010, 16'h0000, lat, st, e);
    n_tests++; if (lat !== 3 || q0 !== 16'hBEEF) begin n_fail++; $display("FAIL err_then_rd got lat=%0d data=%h want 3/beef", lat, q0); end
  endtask

  task automatic test_back_to_back();
    int last, pulses;
    last = -1;
    pulses = 0;
    rd0 = 1'b1; a0 = 16'h0010;
    for (int c = 0; c < 40 && pulses < 4; c++) begin
      tick();
      if (done0) begin
        pulses++;
        n_tests++; if (q0 !== 16'hBEEF) begin n_fail++; $display("FAIL b2b_data got %h want beef", q0); end
        if (last >= 0) begin
          n_tests++; if (c - last !== 4) begin n_fail++; $display("FAIL b2b_period got %0d want 4", c - last); end
        end
        last = c;
      end
    end
    rd0 = 1'b0;
    n_tests++; if (pulses !== 4) begin n_fail++; $display("FAIL b2b_count got %0d want 4", pulses); end
    for (int c = 0; c < 10 && stall0; c++) tick();
    tick();
  endtask

  task automatic test_ignore_busy();
    int lat, st;
    logic e;
    do_op(0, 1'b0, 1'b1, 16'h0020, 16'h7777, lat, st, e);
    rd0 = 1'b1; a0 = 16'h0010;
    tick();
    rd0 = 1'b0;
    wr0 = 1'b1; a0 = 16'h0020; d0 = 16'h1234;
    tick();
    wr0 = 1'b0;
    lat = -1;
    for (int k = 1; k < 20; k++) begin
      if (done0) begin lat = k; break; end
      tick();
    end
    n_tests++; if (lat !== 3 || q0 !== 16'hBEEF) begin n_fail++; $display("FAIL busy_rd got lat=%0d data=%h want 3/beef", lat, q0); end
    tick();
    n_tests++; if (stall0 !== 1'b0) begin n_fail++; $display("FAIL busy_no_queue got stall=%b want 0", stall0); end
    do_op(0, 1'b1, 1'b0, 16'h0020, 16'h0000, lat, st, e);
    n_tests++; if (q0 !== 16'h7777) begin n_fail++; $display("FAIL busy_ignored_wr got %h want 7777", q0); end
  endtask

  task automatic test_reset_abort();
    int lat, st;
    logic e;
    logic seen;
    do_op(0, 1'b0, 1'b1, 16'h0030, 16'h1111, lat, st, e);
    wr0 = 1'b1; a0 = 16'h0030; d0 = 16'h5A5A;
    tick();
    wr0 = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    n_tests++; if (stall0 !== 1'b0 || done0 !== 1'b0 || err0 !== 1'b0 || q0 !== 16'd0) begin n_fail++; $display("FAIL rst_async got stall=%b done=%b err=%b data=%h want 0/0/0/0000", stall0, done0, err0, q0); end
    tick();
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin tick(); if (done0 || stall0) seen = 1'b1; end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_no_done got activity=%b want 0", seen); end
    do_op(0, 1'b1, 1'b0, 16'h0030, 16'h0000, lat, st, e);
    n_tests++; if (q0 !== 16'h1111) begin n_fail++; $display("FAIL rst_aborted_wr got %h want 1111", q0); end
    do_op(0, 1'b0, 1'b1, 16'h0030, 16'h0000, lat, st, e);
    do_op(0, 1'b1, 1'b0, 16'h0030, 16'h0000, lat, st, e);
    n_tests++; if (q0 !== 16'h0000) begin n_fail++; $display("FAIL rst_rewrite got %h want 0000", q0); end
  endtask

  task automatic test_wrap();
    int lat, st;
    logic e;
    do_op(0, 1'b0, 1'b1, 16'h0202, 16'hCAFE, lat, st, e);
    do_op(0, 1'b1, 1'b0, 16'h0002, 16'h0000, lat, st, e);
    n_tests++; if (q0 !== 16'hCAFE) begin n_fail++; $display("FAIL wrap_l3 got %h want cafe", q0); end
    do_op(1, 1'b0, 1'b1, 16'h0202, 16'hCAFE, lat, st, e);
    n_tests++; if (lat !== 1 || st !== 1) begin n_fail++; $display("FAIL l1_wr_timing got lat=%0d stall=%0d want 1/1", lat, st); end
    do_op(1, 1'b1, 1'b0, 16'h0002, 16'h0000, lat, st, e);
    n_tests++; if (lat !== 1 || st !== 1 || q1 !== 16'hCAFE) begin n_fail++; $display("FAIL l1_rd got lat=%0d stall=%0d data=%h want 1/1/cafe", lat, st, q1); end
  endtask

  task automatic test_random();
    logic [15:0] mref [256];
    int          written [$];
    int          lat, st, kind, idx;
    logic        e, rd, wr;
    logic [15:0] a, d, prev;
    for (int it = 0; it < 60; it++) begin
      kind = (written.size() == 0) ? 0 : $urandom_range(0, 2);
      idx  = $urandom_range(0, 255);
      if (kind == 1) idx = written[$urandom_range(0, written.size() - 1)];
      a  = {7'($urandom), 8'(idx), 1'b0};
      d  = 16'($urandom);
      rd = (kind != 0);
      wr = (kind == 0);
      if (kind == 2) begin
        if ($urandom_range(0, 1) == 1) a[0] = 1'b1;
        else begin rd = 1'b1; wr = 1'b1; end
      end
      prev = q0;
      do_op(0, rd, wr, a, d, lat, st, e);
      if (kind == 2) begin
        n_tests++; if (e !== 1'b1 || stall0 !== 1'b0 || q0 !== prev) begin n_fail++; $display("FAIL rand_err it=%0d got err=%b stall=%b data=%h want 1/0/%h", it, e, stall0, q0, prev); end
      end else begin
        n_tests++; if (e !== 1'b0 || lat !== 3 || st !== 3) begin n_fail++; $display("FAIL rand_timing it=%0d got err=%b lat=%0d stall=%0d want 0/3/3", it, e, lat, st); end
        if (kind == 0) begin
          mref[idx] = d;
          written.push_back(idx);
        end else begin
          n_tests++; if (q0 !== mref[idx]) begin n_fail++; $display("FAIL rand_rd it=%0d idx=%0d got %h want %h", it, idx, q0, mref[idx]); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_err();
    test_back_to_back();
    test_ignore_busy();
    test_reset_abort();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
